// File: rtl/timer_sample_arb.sv
// Sampling controller and round-robin arbiter for the 64-bit timer core.
// Owns TIMER_ENABLE/TIMER_SAMPLE and returns one timestamp per granted request.
`timescale 1ns/1ps
module timer_sample_arb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_REQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic [N_REQ-1:0]          req_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic [2*DATA_W-1:0]       ts_o,
    output logic [$clog2(N_REQ)-1:0]  grant_id_o,
    output logic                      busy_o,
    output logic                      running_o,
    output logic                      timer_enable_o,
    output logic                      timer_sample_o,
    input  logic [2*DATA_W-1:0]       timer_value_i
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned SUM_W = ID_W + 1;
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CAPTURE,
        ACK
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] winner_c;
    logic            any_req_c;
    logic [SUM_W-1:0] rr_sum_c;
    logic [ID_W-1:0] rr_idx_c;

    // Round-robin search starting one past the last grant, wrapping modulo N_REQ.
    always_comb begin
        winner_c  = '0;
        any_req_c = 1'b0;
        rr_sum_c  = '0;
        rr_idx_c  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            rr_sum_c = {1'b0, rr_ptr} + SUM_W'(k);
            rr_idx_c = ID_W'((rr_sum_c >= SUM_W'(N_REQ)) ? (rr_sum_c - SUM_W'(N_REQ)) : rr_sum_c);
            if (!any_req_c && req_i[rr_idx_c]) begin
                any_req_c = 1'b1;
                winner_c  = rr_idx_c;
            end
        end
    end

    // Sequencer, running flag and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= PTR_RST;
            grant_id_o     <= '0;
            ack_o          <= '0;
            ts_o           <= '0;
            busy_o         <= 1'b0;
            running_o      <= 1'b0;
            timer_enable_o <= 1'b0;
            timer_sample_o <= 1'b0;
        end else begin
            ack_o          <= '0;
            timer_sample_o <= 1'b0;

            // Stop has priority over start when both pulse together.
            if (stop_i) begin
                running_o      <= 1'b0;
                timer_enable_o <= 1'b0;
            end else if (start_i) begin
                running_o      <= 1'b1;
                timer_enable_o <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        grant_id_o     <= winner_c;
                        rr_ptr         <= winner_c;
                        timer_sample_o <= 1'b1;
                        busy_o         <= 1'b1;
                        state          <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    ts_o  <= timer_value_i;
                    ack_o <= N_REQ'(1) << grant_id_o;
                    state <= ACK;
                end
                ACK: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sample_arb.sv
// Self-checking bench for timer_sample_arb: directed scenarios plus random traffic
// compared against a transaction-timeline reference model and a timer core model.
`timescale 1ns/1ps
module tb_timer_sample_arb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N_REQ  = 4;
    localparam int unsigned TS_W   = 2 * DATA_W;
    localparam int unsigned ID_W   = $clog2(N_REQ);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic [N_REQ-1:0]  req_i = '0;
    logic [N_REQ-1:0]  ack_o;
    logic [TS_W-1:0]   ts_o;
    logic [ID_W-1:0]   grant_id_o;
    logic              busy_o;
    logic              running_o;
    logic              timer_enable_o;
    logic              timer_sample_o;
    logic [TS_W-1:0]   timer_value_i;

    int nvec = 0;
    int nerr = 0;

    timer_sample_arb #(.DATA_W(DATA_W), .N_REQ(N_REQ)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .stop_i         (stop_i),
        .req_i          (req_i),
        .ack_o          (ack_o),
        .ts_o           (ts_o),
        .grant_id_o     (grant_id_o),
        .busy_o         (busy_o),
        .running_o      (running_o),
        .timer_enable_o (timer_enable_o),
        .timer_sample_o (timer_sample_o),
        .timer_value_i  (timer_value_i)
    );

    always #5 clk = ~clk;

    // Timer core stand-in: free-running counter plus a sample register.
    logic [TS_W-1:0] core_cnt = '0;
    logic [TS_W-1:0] core_smp = '0;
    always @(posedge clk) begin
        if (rst) begin
            core_cnt <= '0;
            core_smp <= '0;
        end else begin
            if (timer_enable_o) core_cnt <= core_cnt + TS_W'(1);
            if (timer_sample_o) core_smp <= core_cnt;
        end
    end
    assign timer_value_i = core_smp;

    // Reference model: a timeline of grant events, each fixing its sample/ack cycles.
    int unsigned      cyc = 0;
    int unsigned      g_cyc = 0;
    int unsigned      free_at = 0;
    bit               have = 1'b0;
    bit               m_run = 1'b0;
    int               m_ptr = N_REQ - 1;
    logic [TS_W-1:0]  m_cnt = '0;
    logic [TS_W-1:0]  ts_hold = '0;
    logic [TS_W-1:0]  exp_ts = '0;
    logic [ID_W-1:0]  exp_gid = '0;
    logic [N_REQ-1:0] exp_ack = '0;
    logic             exp_sample = 1'b0;
    logic             exp_busy = 1'b0;

    function automatic int rr_pick(int last, logic [N_REQ-1:0] r);
        logic [N_REQ-1:0] sh;
        for (int k = 1; k <= N_REQ; k++) begin
            sh = r >> ((last + k) % N_REQ);
            if (sh[0]) return (last + k) % N_REQ;
        end
        return last;
    endfunction

    initial begin
        int w;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_run = 1'b0; m_cnt = '0; m_ptr = N_REQ - 1; have = 1'b0;
                exp_ts = '0; exp_gid = '0; free_at = cyc + 1;
            end else begin
                if (have && cyc == g_cyc + 1) ts_hold = m_cnt;
                if (have && cyc == g_cyc + 2) exp_ts = ts_hold;
                if (cyc >= free_at && req_i != '0) begin
                    w = rr_pick(m_ptr, req_i);
                    m_ptr = w; exp_gid = ID_W'(w); have = 1'b1;
                    g_cyc = cyc; free_at = cyc + 4;
                end
                if (m_run) m_cnt = m_cnt + TS_W'(1);
                if (stop_i) m_run = 1'b0;
                else if (start_i) m_run = 1'b1;
            end
            cyc = cyc + 1;
            exp_sample = have && (cyc == g_cyc + 1);
            exp_busy   = have && (cyc >= g_cyc + 1) && (cyc <= g_cyc + 3);
            exp_ack    = (have && cyc == g_cyc + 3) ? (N_REQ'(1) << exp_gid) : '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; req_i = '0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1; stop_i = 1'b0; req_i = '1;
        repeat (3) tick();
        @(negedge clk);
        nvec++; if (ack_o !== '0) begin nerr++; $display("FAIL reset_ack: got %b expected 0", ack_o); end
        nvec++; if (ts_o !== '0) begin nerr++; $display("FAIL reset_ts: got %0h expected 0", ts_o); end
        nvec++; if (grant_id_o !== '0) begin nerr++; $display("FAIL reset_gid: got %0d expected 0", grant_id_o); end
        nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        nvec++; if (running_o !== 1'b0) begin nerr++; $display("FAIL reset_running: got %b expected 0", running_o); end
        nvec++; if (timer_enable_o !== 1'b0) begin nerr++; $display("FAIL reset_enable: got %b expected 0", timer_enable_o); end
        nvec++; if (timer_sample_o !== 1'b0) begin nerr++; $display("FAIL reset_sample: got %b expected 0", timer_sample_o); end
        tick();
    endtask

    task automatic test_first_sample();
        do_reset();
        for (int c = 0; c <= 26; c++) begin
            start_i = (c == 5);
            if (c == 20) req_i = 4'b0001;
            @(negedge clk);
            if (c == 21) begin
                nvec++; if (timer_sample_o !== 1'b1) begin nerr++; $display("FAIL first_sample: got %b expected 1", timer_sample_o); end
                nvec++; if (grant_id_o !== 2'd0) begin nerr++; $display("FAIL first_gid: got %0d expected 0", grant_id_o); end
                nvec++; if (busy_o !== 1'b1) begin nerr++; $display("FAIL first_busy: got %b expected 1", busy_o); end
            end
            if (c == 22) begin
                nvec++; if (timer_sample_o !== 1'b0) begin nerr++; $display("FAIL first_sample_width: got %b expected 0", timer_sample_o); end
            end
            if (c == 23) begin
                nvec++; if (ack_o !== 4'b0001) begin nerr++; $display("FAIL first_ack: got %b expected 0001", ack_o); end
                nvec++; if (ts_o !== TS_W'(15)) begin nerr++; $display("FAIL first_ts: got %0d expected 15", ts_o); end
                nvec++; if (ts_o !== exp_ts) begin nerr++; $display("FAIL first_ts_model: got %0d expected %0d", ts_o, exp_ts); end
                req_i = '0;
            end
            if (c == 24) begin
                nvec++; if (ack_o !== '0) begin nerr++; $display("FAIL first_ack_width: got %b expected 0", ack_o); end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int n_ack;
        int last_c;
        logic [TS_W-1:0] last_ts;
        logic [N_REQ-1:0] e;
        n_ack = 0; last_c = 0; last_ts = '0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            start_i = (c == 0);
            if (c == 5) req_i = 4'b1111;
            @(negedge clk);
            if (ack_o !== '0) begin
                e = N_REQ'(1) << n_ack;
                nvec++; if (ack_o !== e) begin nerr++; $display("FAIL rr_order: got %b expected %b", ack_o, e); end
                nvec++; if (ts_o !== exp_ts) begin nerr++; $display("FAIL rr_ts_model: got %0d expected %0d", ts_o, exp_ts); end
                if (n_ack == 0) begin
                    nvec++; if (c !== 8) begin nerr++; $display("FAIL rr_latency: got cycle %0d expected 8", c); end
                end else begin
                    nvec++; if (c - last_c !== 4) begin nerr++; $display("FAIL rr_spacing: got %0d expected 4", c - last_c); end
                    nvec++; if (ts_o - last_ts !== TS_W'(4)) begin nerr++; $display("FAIL rr_ts_delta: got %0d expected 4", ts_o - last_ts); end
                end
                req_i = req_i & ~ack_o;
                last_c = c; last_ts = ts_o; n_ack++;
            end
            tick();
        end
        nvec++; if (n_ack !== 4) begin nerr++; $display("FAIL rr_count: got %0d acks expected 4", n_ack); end
    endtask

    task automatic test_stop_freeze();
        int seen;
        seen = 0;
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            start_i = (c == 0);
            stop_i  = (c == 30);
            if (c == 40) req_i = req_i | 4'b0001;
            if (c == 50) req_i = req_i | 4'b0010;
            @(negedge clk);
            if (c == 29) begin
                nvec++; if (running_o !== 1'b1) begin nerr++; $display("FAIL stop_pre_running: got %b expected 1", running_o); end
            end
            if (c == 50) begin
                nvec++; if (running_o !== 1'b0) begin nerr++; $display("FAIL stop_running: got %b expected 0", running_o); end
                nvec++; if (timer_enable_o !== 1'b0) begin nerr++; $display("FAIL stop_enable: got %b expected 0", timer_enable_o); end
            end
            if (ack_o !== '0) begin
                nvec++; if (ts_o !== TS_W'(30)) begin nerr++; $display("FAIL stop_frozen_ts: got %0d expected 30", ts_o); end
                nvec++; if (ts_o !== exp_ts) begin nerr++; $display("FAIL stop_ts_model: got %0d expected %0d", ts_o, exp_ts); end
                req_i = req_i & ~ack_o;
                seen++;
            end
            tick();
        end
        nvec++; if (seen !== 2) begin nerr++; $display("FAIL stop_ack_count: got %0d expected 2", seen); end
    endtask

    task automatic test_start_stop_same();
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            start_i = (c == 0) || (c == 5);
            stop_i  = (c == 5);
            @(negedge clk);
            if (c == 5) begin
                nvec++; if (running_o !== 1'b1) begin nerr++; $display("FAIL both_pre_running: got %b expected 1", running_o); end
            end
            if (c == 6) begin
                nvec++; if (running_o !== 1'b0) begin nerr++; $display("FAIL both_running: got %b expected 0", running_o); end
                nvec++; if (timer_enable_o !== 1'b0) begin nerr++; $display("FAIL both_enable: got %b expected 0", timer_enable_o); end
            end
            tick();
        end
        start_i = 1'b0; stop_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n_post;
        n_post = 0;
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            start_i = (c == 0);
            rst     = (c == 10);
            if (c == 3)  req_i = 4'b0001;
            if (c == 8)  req_i = 4'b0100;
            if (c == 11) req_i = 4'b0101;
            @(negedge clk);
            if (c == 10) begin
                nvec++; if (busy_o !== 1'b1) begin nerr++; $display("FAIL mid_busy_capture: got %b expected 1", busy_o); end
            end
            if (c == 11) begin
                nvec++; if (ack_o !== '0) begin nerr++; $display("FAIL mid_no_ack: got %b expected 0", ack_o); end
                nvec++; if (ts_o !== '0) begin nerr++; $display("FAIL mid_ts_clear: got %0d expected 0", ts_o); end
                nvec++; if (busy_o !== 1'b0) begin nerr++; $display("FAIL mid_idle: got %b expected 0", busy_o); end
            end
            if (c == 12) begin
                nvec++; if (grant_id_o !== 2'd0) begin nerr++; $display("FAIL mid_regrant: got %0d expected 0", grant_id_o); end
            end
            if (ack_o !== '0) begin
                if (c == 6) begin
                    nvec++; if (ack_o !== 4'b0001) begin nerr++; $display("FAIL mid_pre_ack: got %b expected 0001", ack_o); end
                    nvec++; if (ts_o !== TS_W'(3)) begin nerr++; $display("FAIL mid_pre_ts: got %0d expected 3", ts_o); end
                end else if (n_post == 0) begin
                    nvec++; if (ack_o !== 4'b0001) begin nerr++; $display("FAIL mid_post_first: got %b expected 0001", ack_o); end
                    nvec++; if (c !== 14) begin nerr++; $display("FAIL mid_post_first_cyc: got %0d expected 14", c); end
                    n_post++;
                end else begin
                    nvec++; if (ack_o !== 4'b0100) begin nerr++; $display("FAIL mid_post_second: got %b expected 0100", ack_o); end
                    nvec++; if (c !== 18) begin nerr++; $display("FAIL mid_post_second_cyc: got %0d expected 18", c); end
                    n_post++;
                end
                req_i = req_i & ~ack_o;
            end
            tick();
        end
        nvec++; if (n_post !== 2) begin nerr++; $display("FAIL mid_post_count: got %0d expected 2", n_post); end
    endtask

    task automatic test_pulse();
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            start_i = (c == 0);
            req_i   = (c == 4) ? 4'b0100 : 4'b0000;
            @(negedge clk);
            if (c == 5) begin
                nvec++; if (timer_sample_o !== 1'b1) begin nerr++; $display("FAIL pulse_sample: got %b expected 1", timer_sample_o); end
                nvec++; if (grant_id_o !== 2'd2) begin nerr++; $display("FAIL pulse_gid: got %0d expected 2", grant_id_o); end
            end
            if (c == 6 || c == 8) begin
                nvec++; if (ack_o !== '0) begin nerr++; $display("FAIL pulse_stray_ack: cycle %0d got %b expected 0", c, ack_o); end
            end
            if (c == 7) begin
                nvec++; if (ack_o !== 4'b0100) begin nerr++; $display("FAIL pulse_ack: got %b expected 0100", ack_o); end
                nvec++; if (ts_o !== TS_W'(4)) begin nerr++; $display("FAIL pulse_ts: got %0d expected 4", ts_o); end
                nvec++; if (ts_o !== exp_ts) begin nerr++; $display("FAIL pulse_ts_model: got %0d expected %0d", ts_o, exp_ts); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            start_i = ($urandom_range(0, 15) == 0);
            stop_i  = ($urandom_range(0, 23) == 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (ack_o[i])         req_i[i] = ($urandom_range(0, 3) == 0);
                else if (!req_i[i])   req_i[i] = ($urandom_range(0, 7) == 0);
                else if ($urandom_range(0, 63) == 0) req_i[i] = 1'b0;
            end
            @(negedge clk);
            nvec++; if (ack_o !== exp_ack) begin nerr++; $display("FAIL rand_ack c%0d: got %b expected %b", c, ack_o, exp_ack); end
            nvec++; if (ts_o !== exp_ts) begin nerr++; $display("FAIL rand_ts c%0d: got %0h expected %0h", c, ts_o, exp_ts); end
            nvec++; if (grant_id_o !== exp_gid) begin nerr++; $display("FAIL rand_gid c%0d: got %0d expected %0d", c, grant_id_o, exp_gid); end
            nvec++; if (busy_o !== exp_busy) begin nerr++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy_o, exp_busy); end
            nvec++; if (timer_sample_o !== exp_sample) begin nerr++; $display("FAIL rand_sample c%0d: got %b expected %b", c, timer_sample_o, exp_sample); end
            nvec++; if (running_o !== m_run) begin nerr++; $display("FAIL rand_running c%0d: got %b expected %b", c, running_o, m_run); end
            nvec++; if (timer_enable_o !== m_run) begin nerr++; $display("FAIL rand_enable c%0d: got %b expected %b", c, timer_enable_o, m_run); end
            tick();
        end
        rst = 1'b0; start_i = 1'b0; stop_i = 1'b0; req_i = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_sample();
        test_round_robin();
        test_stop_freeze();
        test_start_stop_same();
        test_reset_mid();
        test_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
